axi_read_slave_ctrl: RTL and testbench
======================================

# axi_read_slave_ctrl

Sequences the read-slave AR command FIFO: pops one queued read command at a time, walks its burst addresses against a single-port memory, and returns AXI3-style R-channel beats with RID/RRESP/RLAST. Sits between the read-slave command FIFO output and the R channel, and is the only agent that asserts the FIFO's `read_en`. One burst is in flight at a time, in FIFO order.

## Interface
- `tagbits`, 2, ID width. Entry width is 49+tagbits.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fifo_entry`  in  49+tagbits  head entry, valid while `fifo_empty`=0. Fields, MSB first: id[tagbits], addr[32], len[4], size[2], burst[2], lock[2], cache[4], prot[3].
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_en`  out  1  pop pulse, one cycle per accepted command.
- `mem_req`  out  1  memory read strobe.
- `mem_addr`  out  32  byte address of current beat.
- `mem_rdata`  in  32  read data, valid the cycle after `mem_req`.
- `RID`  out  tagbits  ID of the current burst.
- `RDATA`  out  32  beat data.
- `RRESP`  out  2  00 OKAY, 10 SLVERR.
- `RLAST`  out  1  final beat.
- `RVALID`  out  1  beat valid.
- `RREADY`  in  1  master ready.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **States:** IDLE, REQ, CAP, RESP.
- **IDLE:**
  - If `fifo_empty`=0: latch id/addr/len/size/burst, pulse `fifo_read_en`, clear the beat counter.
  - Go to REQ if the command is legal; otherwise go to RESP with the error flag set.
- **REQ:** assert `mem_req` for exactly one cycle with `mem_addr`=current address, then go to CAP.
- **CAP:** register `mem_rdata` into RDATA, then go to RESP.
- **RESP:**
  - Hold `RVALID`=1 with RDATA/RID/RRESP/RLAST stable until `RREADY`.
  - On handshake, if RLAST: go to IDLE.
  - Otherwise: increment the beat counter, advance the address, and go to REQ (error bursts go to RESP).
- **RLAST:** 1 when beat counter == len.
- **Address update, with `bytes`=1<<size:**
  - FIXED (00): unchanged.
  - INCR (01): addr+bytes, modulo 2^32, with no 4 KB boundary check.
  - WRAP (10): `wb`=(len+1)<<size; next=(addr & ~(wb-1)) | ((addr+bytes) & (wb-1)).
- **Illegal commands:** size=11, burst=11, or WRAP with len not in {1,3,7,15}.
  - Produce len+1 beats with RRESP=10 and RDATA=0.
  - `mem_req` is never asserted for these bursts.
- lock, cache and prot are captured in the entry but ignored.

## Timing
- **Reset values:** state IDLE; `fifo_read_en`, `mem_req`, `RVALID`, `RLAST`, `busy`=0; `RID`, `RDATA`, `RRESP`, `mem_addr`=0.
- **Legal burst, `fifo_empty` falling at cycle 0:**
  - `fifo_read_en` in cycle 0.
  - `mem_req` in cycle 1.
  - Data sampled in cycle 2.
  - `RVALID` from cycle 3.
- Each subsequent beat: `RVALID` 3 cycles after the previous handshake. Peak rate is one beat per 3 cycles.
- Error beats: `RVALID` 1 cycle after pop, then 1 cycle after each handshake.
- The next command is not popped in the RLAST handshake cycle. It is popped in the following IDLE cycle, giving a 1-cycle bubble between bursts.
- `fifo_read_en` is never asserted while `fifo_empty`=1 or while `busy`=1.
- **RVALID rules:** `RVALID`, once high, stays high until `RREADY`. It never drops mid-beat, and R outputs never change while `RVALID`=1 and `RREADY`=0.
- A reset asserted mid-burst returns all outputs to reset values immediately. The in-flight command is discarded and the next command is re-fetched from the FIFO head.

## Structure
- Shared package `axi_read_pkg`:
  - burst encodings FIXED/INCR/WRAP
  - RRESP encodings OKAY/SLVERR
  - entry field offsets as localparams derived from tagbits
  - state enum
- One natural sub-module, `axi_burst_addr_gen`:
  - combinational, inputs (addr, size, len, burst), output next address
  - owns the WRAP-mask arithmetic
- The FSM, beat counter and R registers live in the top.

## Test plan
- **Single INCR beat:** id=1, addr=0x100, len=0, size=10, RREADY=1 → one `mem_req` at 0x100; RDATA=mem[0x100], RLAST=1, RRESP=00, RID=1, RVALID at cycle 3.
- **INCR with backpressure:** addr=0x200, len=3, size=10, RREADY low 2 cycles per beat → addresses 0x200/0x204/0x208/0x20C in order; R outputs stable while stalled; RLAST only on beat 4.
- **WRAP:** addr=0x108, len=3, size=10 → addresses 0x108, 0x10C, 0x100, 0x104.
- **FIXED:** addr=0x40, len=2 → 3 beats all at 0x40.
- **Illegal WRAP:** len=2 → 3 beats with RRESP=10 and RDATA=0; zero `mem_req`.
- **Back-to-back and reset:**
  - Two queued commands with id 2 then 3 → pops in order, RID switches only after the first RLAST, 1-cycle bubble between bursts.
  - `rst` low during beat 2 → `RVALID`=0 immediately; after release, the next FIFO head is popped.

Source files
------------

// File: rtl/axi_read_pkg.sv
// Shared encodings, command-entry field offsets and FSM state type for the
// AXI read-slave controller.
package axi_read_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Entry layout, LSB first: prot[3], cache[4], lock[2], burst[2], size[2],
    // len[4], addr[32], id[tagbits]. Only the id field depends on tagbits and
    // it sits on top, so every offset below is tagbits-independent.
    localparam int PROT_LSB     = 0;
    localparam int CACHE_LSB    = 3;
    localparam int LOCK_LSB     = 7;
    localparam int BURST_LSB    = 9;
    localparam int SIZE_LSB     = 11;
    localparam int LEN_LSB      = 13;
    localparam int ADDR_LSB     = 17;
    localparam int ENTRY_BASE_W = 49;
    localparam int ID_LSB       = ENTRY_BASE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAP,
        ST_RESP
    } state_e;

    // Commands the 32-bit data path cannot serve: 8-byte beats, the reserved
    // burst type, and WRAP lengths that are not 2/4/8/16 beats.
    function automatic logic cmd_illegal(input logic [1:0] size,
                                         input logic [1:0] burst,
                                         input logic [3:0] len);
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) &&
                   !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (size == 2'b11) || (burst == 2'b11) || bad_wrap;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts. INCR rolls over at 2^32 and
// does not honour 4 KB boundaries; WRAP stays inside the (len+1)<<size window.
module axi_burst_addr_gen
    import axi_read_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic [3:0]  len_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o
);

    logic [31:0] beat_bytes;
    logic [31:0] wrap_bytes;
    logic [31:0] wrap_mask;
    logic [31:0] incr_addr;

    assign beat_bytes = 32'd1 << size_i;
    assign wrap_bytes = ({28'd0, len_i} + 32'd1) << size_i;
    assign wrap_mask  = wrap_bytes - 32'd1;
    assign incr_addr  = addr_i + beat_bytes;

    // Select the update rule for the current burst type.
    always_comb begin
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = incr_addr;
            BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_read_slave_ctrl.sv
// Read-slave sequencer: pops one AR command at a time from the command FIFO,
// reads each beat from a single-port memory and presents it on the R channel.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a queued command; pops and latches it
//   ST_REQ  | one-cycle memory read strobe at the current beat address
//   ST_CAP  | memory data returns; captured into the RDATA register
//   ST_RESP | beat presented with RVALID until RREADY handshake
module axi_read_slave_ctrl
    import axi_read_pkg::*;
#(
    parameter int tagbits = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ENTRY_BASE_W+tagbits-1:0] fifo_entry,
    input  logic                            fifo_empty,
    output logic                            fifo_read_en,
    output logic                            mem_req,
    output logic [31:0]                     mem_addr,
    input  logic [31:0]                     mem_rdata,
    output logic [tagbits-1:0]              RID,
    output logic [31:0]                     RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RLAST,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic                            busy
);

    state_e             state_q, state_d;
    logic [tagbits-1:0] id_q, id_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [3:0]         len_q, len_d;
    logic [3:0]         beat_q, beat_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         burst_q, burst_d;
    logic               err_q, err_d;

    logic [tagbits-1:0] ent_id;
    logic [31:0]        ent_addr;
    logic [3:0]         ent_len;
    logic [1:0]         ent_size;
    logic [1:0]         ent_burst;
    logic               ent_illegal;
    logic               unused_attr;
    logic [31:0]        next_addr;
    logic               last_beat;

    assign ent_id      = fifo_entry[ID_LSB +: tagbits];
    assign ent_addr    = fifo_entry[ADDR_LSB +: 32];
    assign ent_len     = fifo_entry[LEN_LSB +: 4];
    assign ent_size    = fifo_entry[SIZE_LSB +: 2];
    assign ent_burst   = fifo_entry[BURST_LSB +: 2];
    assign ent_illegal = cmd_illegal(ent_size, ent_burst, ent_len);
    // lock/cache/prot travel with the command but do not affect reads.
    assign unused_attr = ^fifo_entry[LOCK_LSB+1:PROT_LSB];

    assign last_beat = (beat_q == len_q);

    axi_burst_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    // State and burst-context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic, command pop and beat sequencing.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        len_d        = len_q;
        beat_d       = beat_q;
        size_d       = size_q;
        burst_d      = burst_q;
        err_d        = err_q;
        fifo_read_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // rst gates the pop so the FIFO head is not consumed while held in reset.
                if (!fifo_empty && rst) begin
                    fifo_read_en = 1'b1;
                    id_d         = ent_id;
                    addr_d       = ent_addr;
                    len_d        = ent_len;
                    size_d       = ent_size;
                    burst_d      = ent_burst;
                    beat_d       = '0;
                    rdata_d      = '0;
                    err_d        = ent_illegal;
                    state_d      = ent_illegal ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: state_d = ST_CAP;
            ST_CAP: begin
                rdata_d = mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (RREADY) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = next_addr;
                        // Error bursts never touch memory; RDATA stays zero.
                        state_d = err_q ? ST_RESP : ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req  = (state_q == ST_REQ);
    assign mem_addr = addr_q;
    assign RVALID   = (state_q == ST_RESP);
    assign RLAST    = RVALID && last_beat;
    assign RID      = id_q;
    assign RDATA    = rdata_q;
    assign RRESP    = err_q ? RESP_SLVERR : RESP_OKAY;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_read_slave_ctrl.sv
// Directed scoreboard bench for axi_read_slave_ctrl: stimulus pushes expected
// beats and memory addresses into queues, a negedge monitor pops and compares.
module tb_axi_read_slave_ctrl;
    import axi_read_pkg::*;

    localparam int TAGB = 2;
    localparam int EW   = ENTRY_BASE_W + TAGB;

    typedef struct packed {
        logic [TAGB-1:0] id;
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [EW-1:0]   fifo_entry;
    logic            fifo_empty;
    logic            fifo_read_en;
    logic            mem_req;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_rdata = '0;
    logic [TAGB-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    axi_read_slave_ctrl #(.tagbits(TAGB)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_entry   (fifo_entry),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .RID          (RID),
        .RDATA        (RDATA),
        .RRESP        (RRESP),
        .RLAST        (RLAST),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Command FIFO model.
    logic [EW-1:0] fifo_mem [0:15];
    int head = 0;
    int tail = 0;
    assign fifo_empty = (head == tail);
    assign fifo_entry = fifo_mem[head[3:0]];
    always @(posedge clk) if (fifo_read_en && !fifo_empty) head <= head + 1;

    // Memory model: data returns the cycle after the strobe.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'hC3A5_0000;
    endfunction
    always @(posedge clk) if (mem_req) mem_rdata <= mem_val(mem_addr);

    beat_t       exp_q[$];
    logic [31:0] addr_exp_q[$];
    int          pop_q[$];
    int          hs_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // RREADY driver: always ready, or two stall cycles per beat.
    int bp_mode   = 0;
    int stall_cnt = 0;
    initial begin
        RREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) begin
                RREADY = 1'b1;
            end else if (RVALID) begin
                if (stall_cnt < 2) begin
                    RREADY = 1'b0;
                    stall_cnt++;
                end else begin
                    RREADY    = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                RREADY    = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor: stability while stalled, pop legality, memory address order, R beats.
    logic  prev_stall = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = beat_t'({RID, RDATA, RRESP, RLAST});
        if (prev_stall) begin
            chk("rvalid_held", RVALID, 1);
            chk("r_stable", cur, held);
        end
        if (fifo_read_en) begin
            chk("pop_not_empty", fifo_empty, 0);
            chk("pop_not_busy", busy, 0);
            pop_q.push_back(cyc);
        end
        if (mem_req) begin
            if (addr_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_req: got addr 0x%0h, required no request", mem_addr);
            end else begin
                chk("mem_addr", mem_addr, addr_exp_q.pop_front());
            end
        end
        if (RVALID && RREADY) begin
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got id %0d data 0x%0h, required no beat", RID, RDATA);
            end else begin
                e = exp_q.pop_front();
                chk("rid", RID, e.id);
                chk("rdata", RDATA, e.data);
                chk("rresp", RRESP, e.resp);
                chk("rlast", RLAST, e.last);
            end
        end
        prev_stall = RVALID && !RREADY;
        held       = cur;
    end

    task automatic push_cmd(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] size, input logic [1:0] burst);
        fifo_mem[tail[3:0]] = {id, addr, len, size, burst, 2'b01, 4'hF, 3'b101};
        tail++;
    endtask

    task automatic exp_beat(input logic [1:0] id, input logic [31:0] data, input logic [1:0] resp,
                            input logic last);
        beat_t b;
        b.id   = id;
        b.data = data;
        b.resp = resp;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic exp_legal_burst(input logic [1:0] id, input logic [31:0] a0, input logic [31:0] a1,
                                   input logic [31:0] a2, input logic [31:0] a3, input int beats);
        logic [31:0] al [4];
        al[0] = a0; al[1] = a1; al[2] = a2; al[3] = a3;
        for (int i = 0; i < beats; i++) begin
            addr_exp_q.push_back(al[i]);
            exp_beat(id, mem_val(al[i]), RESP_OKAY, i == beats - 1);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && addr_exp_q.size() == 0 && fifo_empty && !busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 500, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_timing();
        pop_q.delete();
        hs_q.delete();
    endtask

    task automatic chk_gap(input string name, input int a, input int b, input int gap);
        chk(name, b - a, gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int found;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_read_en", fifo_read_en, 0);
        chk("rst_rid", RID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #2 rst = 1'b1;

        // Single INCR beat.
        clear_timing();
        @(posedge clk); #2;
        exp_legal_burst(2'd1, 32'h100, 32'h0, 32'h0, 32'h0, 1);
        push_cmd(2'd1, 32'h100, 4'd0, 2'b10, BURST_INCR);
        wait_drain("t1_drain");
        chk("t1_beats", hs_q.size(), 1);
        if (hs_q.size() >= 1 && pop_q.size() >= 1) chk_gap("t1_first_rvalid", pop_q[0], hs_q[0], 3);

        // INCR with backpressure.
        clear_timing();
        bp_mode = 1;
        @(posedge clk); #2;
        exp_legal_burst(2'd0, 32'h200, 32'h204, 32'h208, 32'h20C, 4);
        push_cmd(2'd0, 32'h200, 4'd3, 2'b10, BURST_INCR);
        wait_drain("t2_drain");
        bp_mode = 0;
        chk("t2_beats", hs_q.size(), 4);
        if (hs_q.size() >= 2) chk_gap("t2_beat_spacing", hs_q[0], hs_q[1], 5);

        // WRAP inside a 16-byte window.
        clear_timing();
        @(posedge clk); #2;
        exp_legal_burst(2'd1, 32'h108, 32'h10C, 32'h100, 32'h104, 4);
        push_cmd(2'd1, 32'h108, 4'd3, 2'b10, BURST_WRAP);
        wait_drain("t3_drain");
        chk("t3_beats", hs_q.size(), 4);
        if (hs_q.size() >= 2) chk_gap("t3_beat_rate", hs_q[0], hs_q[1], 3);

        // FIXED.
        @(posedge clk); #2;
        exp_legal_burst(2'd3, 32'h40, 32'h40, 32'h40, 32'h0, 3);
        push_cmd(2'd3, 32'h40, 4'd2, 2'b10, BURST_FIXED);
        wait_drain("t4_drain");

        // Illegal WRAP length: SLVERR beats, no memory access.
        clear_timing();
        @(posedge clk); #2;
        exp_beat(2'd2, 32'h0, RESP_SLVERR, 1'b0);
        exp_beat(2'd2, 32'h0, RESP_SLVERR, 1'b0);
        exp_beat(2'd2, 32'h0, RESP_SLVERR, 1'b1);
        push_cmd(2'd2, 32'h80, 4'd2, 2'b10, BURST_WRAP);
        wait_drain("t5_drain");
        chk("t5_beats", hs_q.size(), 3);
        if (hs_q.size() >= 3 && pop_q.size() >= 1) begin
            chk_gap("t5_err_first", pop_q[0], hs_q[0], 1);
            chk_gap("t5_err_next", hs_q[1], hs_q[2], 1);
        end

        // Illegal size.
        @(posedge clk); #2;
        exp_beat(2'd1, 32'h0, RESP_SLVERR, 1'b1);
        push_cmd(2'd1, 32'h10, 4'd0, 2'b11, BURST_INCR);
        wait_drain("t5b_drain");

        // Back-to-back commands.
        clear_timing();
        @(posedge clk); #2;
        exp_legal_burst(2'd2, 32'h500, 32'h504, 32'h0, 32'h0, 2);
        exp_legal_burst(2'd3, 32'h600, 32'h0, 32'h0, 32'h0, 1);
        push_cmd(2'd2, 32'h500, 4'd1, 2'b10, BURST_INCR);
        push_cmd(2'd3, 32'h600, 4'd0, 2'b10, BURST_INCR);
        wait_drain("t6_drain");
        chk("t6_pops", pop_q.size(), 2);
        if (pop_q.size() >= 2 && hs_q.size() >= 2) chk_gap("t6_bubble", hs_q[1], pop_q[1], 1);

        // Reset during beat 2; the next FIFO head is fetched afterwards.
        clear_timing();
        @(posedge clk); #2;
        exp_legal_burst(2'd1, 32'h300, 32'h304, 32'h308, 32'h30C, 4);
        push_cmd(2'd1, 32'h300, 4'd3, 2'b10, BURST_INCR);
        push_cmd(2'd2, 32'h400, 4'd0, 2'b10, BURST_INCR);
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            @(posedge clk); #2;
            if (hs_q.size() >= 1 && RVALID) found = 1;
        end
        chk("t7_reach_beat2", found, 1);
        rst = 1'b0;
        #1;
        chk("t7_rvalid", RVALID, 0);
        chk("t7_busy", busy, 0);
        chk("t7_rid", RID, 0);
        chk("t7_rdata", RDATA, 0);
        chk("t7_mem_addr", mem_addr, 0);
        exp_q.delete();
        addr_exp_q.delete();
        exp_legal_burst(2'd2, 32'h400, 32'h0, 32'h0, 32'h0, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("t7_read_en_in_rst", fifo_read_en, 0);
        chk("t7_fifo_held", fifo_empty, 0);
        rst = 1'b1;
        wait_drain("t7_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
